complex_nr_acc: RTL and testbench
=================================

COMPLEX_NR_ACC -- requirements
Module: complex_nr_acc

Interface
REQ-001 Parameter DATA_WIDTH, default 8, operand width of the upstream complex multiplier.
REQ-002 Parameter ACC_LEN, default 4, number of products summed per output frame, legal range 1..255.
REQ-003 Parameter GUARD, default 4, extra accumulator bits above the product width.
REQ-004 Derived widths: IN_W = 2*DATA_WIDTH+1 and ACC_W = IN_W+GUARD; all data is signed two's complement.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 sw_rst  input  1  reset, synchronous, active-high.
REQ-007 in_val  input  1  product valid, driven by the multiplier's res_val.
REQ-008 in_ready  output  1  accumulator can take a product, drives the multiplier's res_ready.
REQ-009 in_re  input  IN_W  real part of the product.
REQ-010 in_im  input  IN_W  imaginary part of the product.
REQ-011 acc_val  output  1  frame sum valid.
REQ-012 acc_ready  input  1  downstream consumer accepts the sum.
REQ-013 acc_re  output  ACC_W  real part of the frame sum.
REQ-014 acc_im  output  ACC_W  imaginary part of the frame sum.
REQ-015 acc_ovf  output  1  saturation occurred in the current frame.

Function
REQ-016 FSM with two states: ACCUM and HOLD.
REQ-017 ACCUM: in_ready=1 and acc_val=0; a transfer is in_val&in_ready at a rising edge.
REQ-018 First transfer of a frame (count==0): acc <= sign-extended input, and acc_ovf is cleared and then updated by this load.
REQ-019 Later transfers: acc <= acc + sign-extended input, with the real and imaginary parts handled independently.
REQ-020 Count increments per transfer; the ACC_LEN-th transfer moves the FSM to HOLD and count to 0.
REQ-021 acc_val rises the cycle after the ACC_LEN-th transfer (latency 1).
REQ-022 HOLD: in_ready=0, acc_val=1, and acc_re/acc_im/acc_ovf are held stable; in_val is ignored.
REQ-023 HOLD with acc_ready=1 at an edge: FSM goes to ACCUM; acc_val=0 and in_ready=1 in the next cycle, with no product accepted in the handshake cycle.
REQ-024 acc_re/acc_im/acc_ovf are don't-care to the consumer while acc_val=0, but register contents change only on transfers.
REQ-025 ACC_LEN=1: every transfer goes straight to HOLD, giving pass-through with sign extension.
REQ-026 in_val toggling between transfers does not disturb the partial sum or the count.

Reset
REQ-027 sw_rst=1 at an edge sets FSM=ACCUM, count=0, acc_re=0, acc_im=0 and acc_ovf=0; acc_val is 0 from the following cycle.
REQ-028 in_ready is 0 while sw_rst=1.
REQ-029 sw_rst has priority over any simultaneous transfer or acc_ready handshake.
REQ-030 Reset mid-frame or in HOLD discards the partial or unconsumed sum; the next transfer starts a new frame.

Configuration
REQ-031 Macro COMPLEX_NR_ACC_SAT_EN selects the overflow behaviour.
- Defined: each component's sum saturates to +(2^(ACC_W-1)-1) or -2^(ACC_W-1).
- Defined: acc_ovf is set on any saturating add or load in the frame and stays set until the frame ends.
REQ-032 Macro undefined: sums wrap modulo 2^ACC_W and acc_ovf is tied to 0.

Verification
REQ-033 Default parameters; 4 transfers of 2+16i (product of 2+3i and 4+2i) -> acc=8+64i, acc_val high exactly 1 cycle after the 4th transfer.
REQ-034 4 transfers of -3-5i -> acc=-12-20i (ACC_W=21 two's complement).
REQ-035 Frame complete, acc_ready=0 for 5 cycles with in_val=1 -> in_ready=0, outputs stable, no transfers; acc_ready=1 -> acc_val=0 and in_ready=1 next cycle.
REQ-036 2 transfers, then sw_rst=1 for 1 cycle, then 4 transfers of 1+0i -> acc=4+0i.
REQ-037 GUARD=1 (ACC_W=18), 4 transfers of 65535+0i:
- Macro defined -> acc_re=131071, acc_ovf=1.
- Macro undefined -> acc_re=-4, acc_ovf=0.
REQ-038 ACC_LEN=1, transfers 7-2i then -1+9i -> two HOLD frames in order, equal to the inputs, each acked with acc_ready.

Source files
------------

// File: rtl/complex_nr_acc.sv
// Frame accumulator for complex products: sums ACC_LEN products, then holds the sum until consumed.
// Define COMPLEX_NR_ACC_SAT_EN for saturating sums with an overflow flag; otherwise sums wrap.
module complex_nr_acc #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_LEN    = 4,
   parameter int GUARD      = 4,
   localparam int IN_W      = 2*DATA_WIDTH+1,
   localparam int ACC_W     = IN_W+GUARD
) (
   input  logic                    clk,
   input  logic                    sw_rst,
   input  logic                    in_val,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_re,
   input  logic signed [IN_W-1:0]  in_im,
   output logic                    acc_val,
   input  logic                    acc_ready,
   output logic signed [ACC_W-1:0] acc_re,
   output logic signed [ACC_W-1:0] acc_im,
   output logic                    acc_ovf
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [7:0] LAST = 8'(ACC_LEN-1);

   state_t                  state_q, state_d;
   logic [7:0]              cnt_q, cnt_d;
   logic signed [ACC_W-1:0] re_q, re_d, im_q, im_d;
   logic                    ovf_q, ovf_d;
   logic signed [ACC_W-1:0] sum_re, sum_im;
   logic                    o_re, o_im;

   // One extra bit catches overflow; in wrap mode the flag is never raised.
   function automatic void acc_add(input  logic signed [ACC_W-1:0] a,
                                   input  logic signed [ACC_W-1:0] b,
                                   output logic signed [ACC_W-1:0] s,
                                   output logic                    o);
      logic signed [ACC_W:0] w;
      w = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      s = w[ACC_W-1:0];
      o = 1'b0;
`ifdef COMPLEX_NR_ACC_SAT_EN
      if (w[ACC_W] != w[ACC_W-1]) begin
         o = 1'b1;
         s = w[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      end
`endif
   endfunction

   always_comb begin
      acc_add(re_q, ACC_W'(in_re), sum_re, o_re);
      acc_add(im_q, ACC_W'(in_im), sum_im, o_im);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      re_d    = re_q;
      im_d    = im_q;
      ovf_d   = ovf_q;
      case (state_q)
         ACCUM: begin
            if (in_val) begin
               if (cnt_q == 8'd0) begin
                  re_d  = ACC_W'(in_re);
                  im_d  = ACC_W'(in_im);
                  ovf_d = 1'b0;
               end else begin
                  re_d  = sum_re;
                  im_d  = sum_im;
                  ovf_d = ovf_q | o_re | o_im;
               end
               if (cnt_q == LAST) begin
                  cnt_d   = 8'd0;
                  state_d = HOLD;
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         HOLD: begin
            if (acc_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (sw_rst) begin
         state_q <= ACCUM;
         cnt_q   <= 8'd0;
         re_q    <= '0;
         im_q    <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         re_q    <= re_d;
         im_q    <= im_d;
         ovf_q   <= ovf_d;
      end
   end

   assign in_ready = (state_q == ACCUM) && !sw_rst;
   assign acc_val  = (state_q == HOLD);
   assign acc_re   = re_q;
   assign acc_im   = im_q;
   assign acc_ovf  = ovf_q;

endmodule

// File: tb/tb_complex_nr_acc.sv
// Bench for complex_nr_acc: three instances (default, GUARD=1, ACC_LEN=1) checked every cycle
// against an integer frame model, plus literal expectations for the directed vectors.
module tb_complex_nr_acc;

   logic clk = 1'b0;
   logic sw_rst = 1'b1;
   logic [2:0] v = '0, rdy = '0;
   logic [2:0] ir, av, ov;
   logic signed [16:0] xr [3];
   logic signed [16:0] xi [3];
   logic signed [20:0] ar0, ai0, ar2, ai2;
   logic signed [17:0] ar1, ai1;

   int nchk = 0, nfail = 0;

   // model state per instance
   bit     mhold [3];
   int     mcnt  [3];
   longint mre   [3];
   longint mim   [3];
   bit     movf  [3];
   int     mlen  [3] = '{4, 4, 1};
   int     mw    [3] = '{21, 18, 21};

   always #5 clk = ~clk;

   complex_nr_acc u0 (.clk(clk), .sw_rst(sw_rst), .in_val(v[0]), .in_ready(ir[0]),
      .in_re(xr[0]), .in_im(xi[0]), .acc_val(av[0]), .acc_ready(rdy[0]),
      .acc_re(ar0), .acc_im(ai0), .acc_ovf(ov[0]));
   complex_nr_acc #(.GUARD(1)) u1 (.clk(clk), .sw_rst(sw_rst), .in_val(v[1]), .in_ready(ir[1]),
      .in_re(xr[1]), .in_im(xi[1]), .acc_val(av[1]), .acc_ready(rdy[1]),
      .acc_re(ar1), .acc_im(ai1), .acc_ovf(ov[1]));
   complex_nr_acc #(.ACC_LEN(1)) u2 (.clk(clk), .sw_rst(sw_rst), .in_val(v[2]), .in_ready(ir[2]),
      .in_re(xr[2]), .in_im(xi[2]), .acc_val(av[2]), .acc_ready(rdy[2]),
      .acc_re(ar2), .acc_im(ai2), .acc_ovf(ov[2]));

   function automatic longint out_re(int k);
      case (k)
         0: return longint'(ar0);
         1: return longint'(ar1);
         default: return longint'(ar2);
      endcase
   endfunction

   function automatic longint out_im(int k);
      case (k)
         0: return longint'(ai0);
         1: return longint'(ai1);
         default: return longint'(ai2);
      endcase
   endfunction

   // Plain-integer add with either clamping or modular wrap to a w-bit signed range.
   function automatic longint madd(longint a, longint b, int w, inout bit o);
      longint s, hi, m;
      s  = a + b;
      m  = longint'(1) <<< w;
      hi = m/2 - 1;
`ifdef COMPLEX_NR_ACC_SAT_EN
      if (s > hi) begin s = hi; o = 1'b1; end
      else if (s < -hi-1) begin s = -hi-1; o = 1'b1; end
`else
      s = ((s % m) + m) % m;
      if (s > hi) s = s - m;
`endif
      return s;
   endfunction

   task automatic chk(string nm, longint act, longint exp);
      nchk++;
      if (act != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (sw_rst) begin
            mhold[k] = 0; mcnt[k] = 0; mre[k] = 0; mim[k] = 0; movf[k] = 0;
         end else if (!mhold[k]) begin
            if (v[k]) begin
               if (mcnt[k] == 0) begin
                  mre[k] = longint'(xr[k]); mim[k] = longint'(xi[k]); movf[k] = 0;
               end else begin
                  mre[k] = madd(mre[k], longint'(xr[k]), mw[k], movf[k]);
                  mim[k] = madd(mim[k], longint'(xi[k]), mw[k], movf[k]);
               end
               mcnt[k]++;
               if (mcnt[k] == mlen[k]) begin mcnt[k] = 0; mhold[k] = 1; end
            end
         end else if (rdy[k]) begin
            mhold[k] = 0;
         end
      end
   end

   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("u%0d.in_ready", k), longint'(ir[k]), longint'(!mhold[k] && !sw_rst));
         chk($sformatf("u%0d.acc_val", k), longint'(av[k]), longint'(mhold[k]));
         if (mhold[k]) begin
            chk($sformatf("u%0d.acc_re", k), out_re(k), mre[k]);
            chk($sformatf("u%0d.acc_im", k), out_im(k), mim[k]);
            chk($sformatf("u%0d.acc_ovf", k), longint'(ov[k]), longint'(movf[k]));
         end
      end
   end

   task automatic step();
      @(posedge clk); #2;
   endtask

   task automatic xfer(int k, longint r, longint i, int n, bit gap);
      for (int j = 0; j < n; j++) begin
         v[k] = 1'b1; xr[k] = 17'(r); xi[k] = 17'(i);
         step();
         if (gap) begin v[k] = 1'b0; xr[k] = 17'sd99; step(); end
      end
      v[k] = 1'b0;
   endtask

   task automatic ack(int k);
      rdy[k] = 1'b1;
      step();
      rdy[k] = 1'b0;
   endtask

   task automatic lit(int k, longint r, longint i, longint o);
      @(negedge clk); #1;
      chk($sformatf("lit u%0d acc_val", k), longint'(av[k]), 1);
      chk($sformatf("lit u%0d acc_re", k), out_re(k), r);
      chk($sformatf("lit u%0d acc_im", k), out_im(k), i);
      chk($sformatf("lit u%0d acc_ovf", k), longint'(ov[k]), o);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin xr[k] = '0; xi[k] = '0; end
      repeat (2) step();
      @(negedge clk); #1;
      chk("rst in_ready", longint'(ir[0]), 0);
      chk("rst acc_val", longint'(av[0]), 0);
      chk("rst acc_re", out_re(0), 0);
      chk("rst acc_ovf", longint'(ov[0]), 0);
      step();
      sw_rst = 1'b0;
      step();

      // 4 x (2+16i)
      xfer(0, 2, 16, 4, 0);
      lit(0, 8, 64, 0);

      // consumer stalls while upstream keeps offering
      v[0] = 1'b1; xr[0] = 17'sd5; xi[0] = 17'sd5;
      repeat (5) step();
      lit(0, 8, 64, 0);
      chk("stall in_ready", longint'(ir[0]), 0);
      v[0] = 1'b0;
      ack(0);
      @(negedge clk); #1;
      chk("ack in_ready", longint'(ir[0]), 1);
      chk("ack acc_val", longint'(av[0]), 0);

      // 4 x (-3-5i) with idle cycles between transfers
      xfer(0, -3, -5, 4, 1);
      lit(0, -12, -20, 0);
      ack(0);

      // reset mid-frame, offered product at the reset edge is dropped
      xfer(0, 5, 5, 2, 0);
      sw_rst = 1'b1; v[0] = 1'b1; xr[0] = 17'sd9; xi[0] = 17'sd9;
      step();
      sw_rst = 1'b0; v[0] = 1'b0;
      xfer(0, 1, 0, 4, 0);
      lit(0, 4, 0, 0);
      ack(0);

      // narrow guard: 4 x 65535
      xfer(1, 65535, 0, 4, 0);
`ifdef COMPLEX_NR_ACC_SAT_EN
      lit(1, 131071, 0, 1);
`else
      lit(1, -4, 0, 0);
`endif
      ack(1);

      // pass-through frames
      xfer(2, 7, -2, 1, 0);
      lit(2, 7, -2, 0);
      ack(2);
      xfer(2, -1, 9, 1, 0);
      lit(2, -1, 9, 0);
      ack(2);

      // reset while holding discards the sum
      xfer(0, 3, 3, 4, 0);
      lit(0, 12, 12, 0);
      sw_rst = 1'b1;
      step();
      sw_rst = 1'b0;
      @(negedge clk); #1;
      chk("hold rst acc_val", longint'(av[0]), 0);
      chk("hold rst in_ready", longint'(ir[0]), 1);
      chk("hold rst acc_re", out_re(0), 0);

      repeat (3) step();
      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
